// File: rtl/vvm_cfg_sequencer.sv
// vvm_cfg_sequencer
//
// Configuration sequencer for the vvm_dsp down-converter / CIC / IIR chain.
// A request (LO FTW, CIC period, CIC shift, IIR shift, settle frame count)
// is applied to the DSP in a single cycle. The DSP is then held in reset for
// FLUSH_CYCLES cycles to flush its pipelines, and a programmable number of
// result frames are discarded before measurements are flagged valid. While
// settling or locked, the result strobe is supervised. If no frame arrives
// within TIMEOUT cycles, the sequencer drops back to IDLE and raises a
// sticky error.
//
// Handshake: a request transfers on a rising sample_clk edge where
// cfg_valid && cfg_ready. cfg_ready depends only on state (low in FLUSH), so
// it never depends combinationally on cfg_valid. A requester may hold
// cfg_valid high with stable fields until the transfer edge.
//
// Ports
//   sample_clk, sample_rst_n : clock, async active-low reset
//   cfg_*                    : request fields; cfg_valid / cfg_ready handshake
//   ftw, cic_period, cic_shift, iir_shift : applied configuration to vvm_dsp
//   dsp_rst                  : active-high reset to vvm_dsp
//   dsp_strobe               : result strobe from vvm_dsp (frame = rising edge)
//   meas_valid, meas_strobe  : settled flag, one-cycle pulse per locked frame
//   busy, err, cfg_seq       : status (FLUSH/SETTLE, sticky timeout, accept count)
//   dbg_state                : current FSM state (0 IDLE, 1 FLUSH, 2 SETTLE, 3 LOCKED)
module vvm_cfg_sequencer #(
  parameter int FLUSH_CYCLES   = 16,
  parameter int TIMEOUT        = 65535,
  parameter int DEF_CIC_PERIOD = 100,
  parameter int DEF_CIC_SHIFT  = 2,
  parameter int DEF_IIR_SHIFT  = 4
) (
  input  logic        sample_clk,
  input  logic        sample_rst_n,
  input  logic [31:0] cfg_ftw,
  input  logic [12:0] cfg_cic_period,
  input  logic [3:0]  cfg_cic_shift,
  input  logic [5:0]  cfg_iir_shift,
  input  logic [7:0]  cfg_settle,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [31:0] ftw,
  output logic [12:0] cic_period,
  output logic [3:0]  cic_shift,
  output logic [5:0]  iir_shift,
  output logic        dsp_rst,
  input  logic        dsp_strobe,
  output logic        meas_valid,
  output logic        meas_strobe,
  output logic        busy,
  output logic        err,
  output logic [7:0]  cfg_seq,
  output logic [1:0]  dbg_state
);

  // Flush counter holds FLUSH_CYCLES-1 down to 0; timeout counter holds
  // TIMEOUT-1 down to 0.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] flush_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    settle_cnt;
  logic          strobe_d;

  logic accept, frame, flush_done, to_done, timeout_hit;

  assign accept     = cfg_valid && cfg_ready;
  assign frame      = dsp_strobe && !strobe_d;
  assign flush_done = (flush_cnt == '0);
  assign to_done    = (to_cnt == '0);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_FLUSH:
        if (flush_done) state_d = (settle_cnt == 8'd0) ? ST_LOCKED : ST_SETTLE;
      ST_SETTLE:
        if (frame) begin
          if (settle_cnt == 8'd1) state_d = ST_LOCKED;
        end else if (to_done) begin
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end
      ST_LOCKED:
        // A frame on the terminal count keeps the lock alive.
        if (!frame && to_done) begin
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase
    // A new request overrides any frame or timeout on the same edge.
    if (accept) begin
      state_d     = ST_FLUSH;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q     <= ST_IDLE;
      ftw         <= '0;
      cic_period  <= 13'(DEF_CIC_PERIOD);
      cic_shift   <= 4'(DEF_CIC_SHIFT);
      iir_shift   <= 6'(DEF_IIR_SHIFT);
      err         <= 1'b0;
      cfg_seq     <= '0;
      strobe_d    <= 1'b0;
      meas_strobe <= 1'b0;
      flush_cnt   <= '0;
      to_cnt      <= '0;
      settle_cnt  <= '0;
    end else begin
      state_q     <= state_d;
      strobe_d    <= dsp_strobe;
      meas_strobe <= (state_q == ST_LOCKED) && frame && !accept;
      if (accept) begin
        ftw        <= cfg_ftw;
        cic_period <= cfg_cic_period;
        cic_shift  <= cfg_cic_shift;
        iir_shift  <= cfg_iir_shift;
        settle_cnt <= cfg_settle;
        flush_cnt  <= FLUSH_LOAD;
        cfg_seq    <= cfg_seq + 8'd1;
        err        <= 1'b0;
      end else begin
        if (timeout_hit) err <= 1'b1;
        if (state_q == ST_FLUSH) begin
          // Arm the watchdog as the DSP leaves reset (SETTLE or LOCKED).
          if (flush_done) to_cnt <= TO_LOAD;
          else            flush_cnt <= flush_cnt - 1'b1;
        end
        if (state_q == ST_SETTLE || state_q == ST_LOCKED) begin
          if (frame) begin
            to_cnt <= TO_LOAD;
            if (state_q == ST_SETTLE) settle_cnt <= settle_cnt - 8'd1;
          end else if (!to_done) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
      end
    end
  end

  assign cfg_ready  = (state_q != ST_FLUSH);
  assign dsp_rst    = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
  assign meas_valid = (state_q == ST_LOCKED);
  assign busy       = (state_q == ST_FLUSH) || (state_q == ST_SETTLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vvm_cfg_sequencer.sv
// Bench for vvm_cfg_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against a time-stamp based behavioural model.
module tb_vvm_cfg_sequencer;

  localparam int FLUSH_CYCLES = 16;
  localparam int TIMEOUT      = 500;

  // ---------------- clock / reset ----------------
  logic        sample_clk = 1'b0;
  logic        sample_rst_n = 1'b0;
  always #5 sample_clk = ~sample_clk;

  logic [31:0] cfg_ftw = '0;
  logic [12:0] cfg_cic_period = '0;
  logic [3:0]  cfg_cic_shift = '0;
  logic [5:0]  cfg_iir_shift = '0;
  logic [7:0]  cfg_settle = '0;
  logic        cfg_valid = 1'b0;
  logic        dsp_strobe = 1'b0;
  logic        cfg_ready, dsp_rst, meas_valid, meas_strobe, busy, err;
  logic [31:0] ftw;
  logic [12:0] cic_period;
  logic [3:0]  cic_shift;
  logic [5:0]  iir_shift;
  logic [7:0]  cfg_seq;
  logic [1:0]  dbg_state;

  vvm_cfg_sequencer #(
    .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT),
    .DEF_CIC_PERIOD(100), .DEF_CIC_SHIFT(2), .DEF_IIR_SHIFT(4)
  ) dut (
    .sample_clk(sample_clk), .sample_rst_n(sample_rst_n),
    .cfg_ftw(cfg_ftw), .cfg_cic_period(cfg_cic_period),
    .cfg_cic_shift(cfg_cic_shift), .cfg_iir_shift(cfg_iir_shift),
    .cfg_settle(cfg_settle), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ftw(ftw), .cic_period(cic_period), .cic_shift(cic_shift),
    .iir_shift(iir_shift), .dsp_rst(dsp_rst), .dsp_strobe(dsp_strobe),
    .meas_valid(meas_valid), .meas_strobe(meas_strobe), .busy(busy),
    .err(err), .cfg_seq(cfg_seq), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode 0 idle, 1 flush, 2 settle, 3 locked. Durations are tracked as
  // differences between edge numbers rather than as down-counters.
  int          m_mode;
  longint      cyc, t_acc, t_ref;
  int          m_target, m_frames;
  logic        m_prev, m_err, m_strobe, m_frame;
  logic [7:0]  m_seq;
  logic [31:0] m_ftw;
  logic [12:0] m_period;
  logic [3:0]  m_cshift;
  logic [5:0]  m_ishift;

  always @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      m_mode = 0; cyc = 0; t_acc = 0; t_ref = 0; m_target = 0; m_frames = 0;
      m_prev = 0; m_err = 0; m_strobe = 0; m_seq = 0;
      m_ftw = 0; m_period = 13'd100; m_cshift = 4'd2; m_ishift = 6'd4;
    end else begin
      cyc++;
      m_frame  = dsp_strobe && !m_prev;
      m_prev   = dsp_strobe;
      m_strobe = 0;
      if (cfg_valid && m_mode != 1) begin
        m_mode = 1; t_acc = cyc; m_err = 0; m_seq = m_seq + 8'd1;
        m_ftw = cfg_ftw; m_period = cfg_cic_period;
        m_cshift = cfg_cic_shift; m_ishift = cfg_iir_shift;
        m_target = int'(cfg_settle); m_frames = 0;
      end else if (m_mode == 1) begin
        if (cyc - t_acc == FLUSH_CYCLES) begin
          m_mode = (m_target == 0) ? 3 : 2;
          t_ref  = cyc;
        end
      end else if (m_mode >= 2) begin
        if (m_frame) begin
          t_ref = cyc;
          if (m_mode == 3) m_strobe = 1;
          else begin
            m_frames++;
            if (m_frames == m_target) m_mode = 3;
          end
        end else if (cyc - t_ref == TIMEOUT) begin
          m_mode = 0; m_err = 1;
        end
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge sample_clk) begin
    if (chk_en && sample_rst_n) begin
      chk("cfg_ready",   32'(cfg_ready),   32'(m_mode != 1));
      chk("dsp_rst",     32'(dsp_rst),     32'(m_mode <= 1));
      chk("meas_valid",  32'(meas_valid),  32'(m_mode == 3));
      chk("busy",        32'(busy),        32'(m_mode == 1 || m_mode == 2));
      chk("dbg_state",   32'(dbg_state),   32'(m_mode));
      chk("meas_strobe", 32'(meas_strobe), 32'(m_strobe));
      chk("err",         32'(err),         32'(m_err));
      chk("cfg_seq",     32'(cfg_seq),     32'(m_seq));
      chk("ftw",         ftw,              m_ftw);
      chk("cic_period",  32'(cic_period),  32'(m_period));
      chk("cic_shift",   32'(cic_shift),   32'(m_cshift));
      chk("iir_shift",   32'(iir_shift),   32'(m_ishift));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_accept(input logic [31:0] f, input logic [12:0] p,
                           input logic [3:0] cs, input logic [5:0] is,
                           input logic [7:0] st);
    int n = 0;
    while (!cfg_ready && n < 100) begin @(negedge sample_clk); n++; end
    chk("accept_ready_wait", 32'(n < 100), 32'd1);
    cfg_ftw = f; cfg_cic_period = p; cfg_cic_shift = cs;
    cfg_iir_shift = is; cfg_settle = st; cfg_valid = 1'b1;
    @(negedge sample_clk);
    cfg_valid = 1'b0;
  endtask

  // Drives one strobe pulse; returns the meas_strobe cycles seen meanwhile.
  task automatic pulse(input int hi, input int lo, output int ms);
    ms = 0;
    dsp_strobe = 1'b1;
    repeat (hi) begin @(negedge sample_clk); if (meas_strobe) ms++; end
    dsp_strobe = 1'b0;
    repeat (lo) begin @(negedge sample_clk); if (meas_strobe) ms++; end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!cfg_ready && cnt < 1000) begin cnt++; @(negedge sample_clk); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt, ms, p_strobe, p_valid;
    repeat (3) @(negedge sample_clk);
    sample_rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (50) @(negedge sample_clk);
    chk("rst_dsp_rst",    32'(dsp_rst), 32'd1);
    chk("rst_cic_period", 32'(cic_period), 32'd100);
    chk("rst_cic_shift",  32'(cic_shift), 32'd2);
    chk("rst_iir_shift",  32'(iir_shift), 32'd4);
    chk("rst_ftw",        ftw, 32'd0);
    chk("rst_cfg_ready",  32'(cfg_ready), 32'd1);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_err",        32'(err), 32'd0);

    // Accept with settle=3; flush length and settle frame count.
    do_accept(32'h3670A3D7, 13'd100, 4'd3, 6'd5, 8'd3);
    chk("acc1_ftw", ftw, 32'h3670A3D7);
    chk("acc1_seq", 32'(cfg_seq), 32'd1);
    wait_ready(cnt);
    chk("acc1_ready_low_cycles", 32'(cnt), 32'd16);
    chk("acc1_dsp_rst_after_flush", 32'(dsp_rst), 32'd0);
    pulse(2, 3, ms);
    pulse(2, 3, ms);
    chk("acc1_valid_after_2", 32'(meas_valid), 32'd0);
    pulse(2, 3, ms);
    chk("acc1_valid_after_3", 32'(meas_valid), 32'd1);
    chk("acc1_no_strobe_3rd", 32'(ms), 32'd0);
    pulse(2, 3, ms);
    chk("acc1_strobe_4th", 32'(ms), 32'd1);

    // settle=0: straight to LOCKED; held strobe is one frame.
    do_accept(32'h12345678, 13'd50, 4'd1, 6'd2, 8'd0);
    cnt = 0;
    while (!meas_valid && cnt < 1000) begin cnt++; @(negedge sample_clk); end
    chk("s0_valid_cycles", 32'(cnt), 32'd16);
    pulse(10, 3, ms);
    chk("s0_held_strobe", 32'(ms), 32'd1);

    // Re-accept during SETTLE.
    do_accept(32'hA5A5A5A5, 13'd200, 4'd4, 6'd6, 8'd3);
    wait_ready(cnt);
    pulse(2, 3, ms);
    chk("resettle_busy", 32'(busy), 32'd1);
    do_accept(32'h0BADF00D, 13'd300, 4'd5, 6'd7, 8'd2);
    chk("resettle_seq", 32'(cfg_seq), 32'd4);
    cnt = 0;
    while (dsp_rst && cnt < 1000) begin cnt++; @(negedge sample_clk); end
    chk("resettle_rst_cycles", 32'(cnt), 32'd16);
    pulse(2, 3, ms);
    chk("resettle_valid_after_1", 32'(meas_valid), 32'd0);
    pulse(2, 3, ms);
    chk("resettle_valid_after_2", 32'(meas_valid), 32'd1);

    // Timeout from LOCKED.
    dsp_strobe = 1'b1;
    @(negedge sample_clk);
    dsp_strobe = 1'b0;
    cnt = 0;
    while (!err && cnt < 2000) begin @(negedge sample_clk); cnt++; end
    chk("to_cycles", 32'(cnt), 32'd500);
    chk("to_meas_valid", 32'(meas_valid), 32'd0);
    chk("to_dsp_rst", 32'(dsp_rst), 32'd1);
    chk("to_state", 32'(dbg_state), 32'd0);
    do_accept(32'h1, 13'd10, 4'd0, 6'd0, 8'd1);
    chk("to_err_cleared", 32'(err), 32'd0);

    // Randomized traffic in segments of differing strobe/request density.
    for (int seg = 0; seg < 8; seg++) begin
      p_strobe = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 10 : 50);
      p_valid  = (seg % 2 == 0) ? 400 : 80;
      for (int i = 0; i < 600; i++) begin
        cfg_valid      = ($urandom_range(0, p_valid - 1) == 0);
        cfg_ftw        = $urandom;
        cfg_cic_period = 13'($urandom);
        cfg_cic_shift  = 4'($urandom);
        cfg_iir_shift  = 6'($urandom);
        cfg_settle     = 8'($urandom_range(0, 4));
        dsp_strobe     = ($urandom_range(0, 99) < p_strobe);
        @(negedge sample_clk);
      end
    end
    cfg_valid = 1'b0;
    dsp_strobe = 1'b0;

    // cfg_seq wrap after 256 accepts from reset.
    sample_rst_n = 1'b0;
    repeat (2) @(negedge sample_clk);
    sample_rst_n = 1'b1;
    for (int i = 0; i < 255; i++) do_accept(32'(i), 13'(i), 4'(i), 6'(i), 8'd0);
    chk("wrap_seq_255", 32'(cfg_seq), 32'd255);
    do_accept(32'hFFFF0000, 13'd7, 4'd7, 6'd7, 8'd3);
    chk("wrap_seq_0", 32'(cfg_seq), 32'd0);

    // Asynchronous reset mid-SETTLE.
    wait_ready(cnt);
    pulse(2, 3, ms);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    @(posedge sample_clk);
    #2 sample_rst_n = 1'b0;
    #1;
    chk("arst_dsp_rst",    32'(dsp_rst), 32'd1);
    chk("arst_meas_valid", 32'(meas_valid), 32'd0);
    chk("arst_busy",       32'(busy), 32'd0);
    chk("arst_seq",        32'(cfg_seq), 32'd0);
    chk("arst_ftw",        ftw, 32'd0);
    chk("arst_cic_period", 32'(cic_period), 32'd100);
    chk("arst_cic_shift",  32'(cic_shift), 32'd2);
    chk("arst_iir_shift",  32'(iir_shift), 32'd4);
    chk("arst_cfg_ready",  32'(cfg_ready), 32'd1);
    chk("arst_state",      32'(dbg_state), 32'd0);
    @(negedge sample_clk);
    sample_rst_n = 1'b1;
    repeat (5) @(negedge sample_clk);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
